load_store_unit: RTL
====================

# load_store_unit

Sequencer between the execute stage and the data memory. It accepts one load or store per handshake and computes the effective address. It drives the memory's address, opcode, data and read/write strobes for one access, then waits the memory latency. For loads it returns a zero- or sign-extended result with its destination register for writeback.

## Interface

Parameters:
- DEPTH, 32: number of data-memory entries; a legal effective address (EA) is 0..DEPTH-1.
- MEM_LAT, 1: cycles from the ISSUE cycle until mem_read_data is valid (legal range 1..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute stage offers a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_opcode  in  6  primary opcode.
- req_ra_zero  in  1  RA field is 0; the base is then 0 instead of req_ra_val.
- req_ra_val  in  64  base register value.
- req_imm  in  16  D/DS field.
- req_rs_val  in  64  store data.
- req_rt  in  5  load destination register.
- mem_address  out  64  data-memory entry index.
- mem_write_data  out  64  store data (the memory truncates by opcode).
- mem_opcode  out  6  opcode forwarded to memory.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_read_data  in  64  memory read data.
- resp_valid  out  1  one-cycle completion pulse (loads, stores and errors).
- resp_err  out  1  qualifies resp_valid; the request was not performed.
- wb_valid  out  1  load result valid; equals resp_valid & load & !resp_err.
- wb_rt  out  5  destination register.
- wb_data  out  64  extended load result.

## Operation

- Supported opcodes:
  - Loads: lwz 32, lbz 34, lhz 40, lha 42, ld 58.
  - Stores: stw 36, sth 44, std 62.
  - Any other opcode is an error.
- Effective address: EA = base + disp, a 64-bit modular add with no overflow detection.
  - D-form: disp = sext64(imm).
  - DS-form (58, 62): disp = sext64({imm[15:2], 2'b00}); imm[1:0] must be 0, otherwise the request is an error.
- Range check: EA >= DEPTH (unsigned compare) is an error.
- FSM states are IDLE, ISSUE, WAIT and RESP.
  - IDLE: req_ready=1. On req_valid, latch all req_* fields and the EA.
    - Error request: go to RESP with resp_err=1 and no memory strobe.
    - Otherwise: go to ISSUE.
  - ISSUE (1 cycle): mem_address=EA and mem_opcode=opcode. mem_read=1 for loads, mem_write=1 for stores, and mem_write_data=rs_val. Load counter to MEM_LAT, then go to WAIT.
  - WAIT: mem_address and mem_opcode are held and strobes are 0. Counter decrements each cycle. On the cycle the counter reaches 1, capture mem_read_data (loads only) and go to RESP.
  - RESP (1 cycle): resp_valid=1.
    - Loads: wb_valid=1, with wb_rt and wb_data. wb_data by opcode:
      - lbz: zext(rd[7:0]).
      - lhz: zext(rd[15:0]).
      - lha: sext(rd[15:0]).
      - lwz: zext(rd[31:0]).
      - ld: rd.
    - Stores: wb_valid=0.
    - Then go to IDLE.
- Address parking: in IDLE and RESP, mem_address = 64'hFFFF_FFFF_FFFF_FFFF. Every access therefore presents an address transition, even back-to-back accesses to the same entry.
- Only one request is in flight. req_valid is ignored outside IDLE, and a request waiting there is not consumed.

## Timing

- Reset (asynchronous, takes effect immediately):
  - State is IDLE and req_ready=1.
  - mem_read, mem_write, resp_valid, resp_err and wb_valid are 0.
  - mem_address is all-ones. mem_write_data, mem_opcode, wb_rt and wb_data are 0.
- Reset mid-operation: strobes drop asynchronously and no response is issued. A store reset in ISSUE may or may not have written; software must not rely on it.
- Timing is measured from the acceptance edge T (req_valid & req_ready).
  - Legal request: ISSUE in cycle T+1, WAIT in T+2..T+1+MEM_LAT, RESP in T+2+MEM_LAT. The next acceptance is possible at T+3+MEM_LAT.
  - Error request: RESP in cycle T+1 and the next acceptance is at T+2.
- All outputs are registered except req_ready, which is decoded from state.
- Strobes are high for exactly one cycle per legal request.

## Test plan

- Load byte, MEM_LAT=1: ld mem[5]=64'h0000_0000_0000_0080, lbz with ra_zero=1, imm=5, rt=3.
  - Cycle T+1: mem_address=5, mem_read=1.
  - Cycle T+3: wb_valid=1, wb_rt=3, wb_data=64'h80.
- Sign extension: mem[2]=64'h8001, lha with ra_val=1, imm=1 -> EA=2, wb_data=64'hFFFF_FFFF_FFFF_8001. The same entry with lhz -> 64'h8001.
- Store then load, same address back-to-back:
  - std with ra_val=8, imm=16'hFFF8 (disp -8), EA=0, rs_val=64'hDEAD_BEEF_0123_4567. mem_write pulses once with mem_opcode=62, and resp_valid fires with wb_valid=0.
  - ld with EA=0 follows: mem_address goes FFFF..->0 again, and wb_data=64'hDEAD_BEEF_0123_4567.
- Errors, each giving resp_valid=1 and resp_err=1 at T+1 with no strobe:
  - lwz with EA=32 (DEPTH=32).
  - ld with imm=16'h0006 (DS low bits nonzero).
  - opcode 31.
- Back-pressure and reset:
  - req_valid is held high during WAIT with a second request; it is accepted exactly at T+3+MEM_LAT.
  - rst_n pulsed low during WAIT clears mem_read/mem_write/resp_valid immediately, returns to IDLE with req_ready=1, and no response follows.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequencer between the execute stage and the data memory. Accepts
//            one load/store per handshake, computes the effective address,
//            issues a single memory access, waits out the memory latency and
//            returns a zero/sign-extended load result for writeback.
// Ports    : clk, rst_n (async active-low)
//            req_*   : request from execute (valid/ready handshake)
//            mem_*   : data-memory address/opcode/data/strobes, read data in
//            resp_*  : one-cycle completion pulse with error qualifier
//            wb_*    : load writeback (valid, destination, extended data)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int DEPTH   = 32,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic        req_ra_zero,
  input  logic [63:0] req_ra_val,
  input  logic [15:0] req_imm,
  input  logic [63:0] req_rs_val,
  input  logic [4:0]  req_rt,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic [5:0]  mem_opcode,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic        wb_valid,
  output logic [4:0]  wb_rt,
  output logic [63:0] wb_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LHA = 6'd42;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_LD  = 6'd58;
  localparam logic [5:0] OP_STD = 6'd62;

  // Idle address: guarantees an address transition on every access.
  localparam logic [63:0] PARK_ADDR = '1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [4:0]  rt_q, rt_d;
  logic        is_load_q, is_load_d;

  logic [63:0] mem_address_q, mem_address_d;
  logic [63:0] mem_write_data_q, mem_write_data_d;
  logic [5:0]  mem_opcode_q, mem_opcode_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rt_q, wb_rt_d;
  logic [63:0] wb_data_q, wb_data_d;

  // --------------------------------------------------------------------------
  // Request decode and effective address
  // --------------------------------------------------------------------------
  logic        req_is_load, req_is_store, req_is_ds, req_err;
  logic [63:0] req_base, req_disp, req_ea;

  always_comb begin
    req_is_load  = (req_opcode == OP_LWZ) || (req_opcode == OP_LBZ) ||
                   (req_opcode == OP_LHZ) || (req_opcode == OP_LHA) ||
                   (req_opcode == OP_LD);
    req_is_store = (req_opcode == OP_STW) || (req_opcode == OP_STH) ||
                   (req_opcode == OP_STD);
    req_is_ds    = (req_opcode == OP_LD) || (req_opcode == OP_STD);
    req_base     = req_ra_zero ? 64'd0 : req_ra_val;
    // DS-form drops the two low displacement bits; they must be zero.
    req_disp     = req_is_ds ? {{48{req_imm[15]}}, req_imm[15:2], 2'b00}
                             : {{48{req_imm[15]}}, req_imm};
    req_ea       = req_base + req_disp;
    req_err      = !(req_is_load || req_is_store) ||
                   (req_is_ds && (req_imm[1:0] != 2'b00)) ||
                   (req_ea >= 64'(DEPTH));
  end

  // --------------------------------------------------------------------------
  // State and sequential storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      opcode_q         <= '0;
      rt_q             <= '0;
      is_load_q        <= 1'b0;
      mem_address_q    <= PARK_ADDR;
      mem_write_data_q <= '0;
      mem_opcode_q     <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_rt_q          <= '0;
      wb_data_q        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      opcode_q         <= opcode_d;
      rt_q             <= rt_d;
      is_load_q        <= is_load_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_opcode_q     <= mem_opcode_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      wb_valid_q       <= wb_valid_d;
      wb_rt_q          <= wb_rt_d;
      wb_data_q        <= wb_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic, request latch and latency counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opcode_d  = opcode_q;
    rt_d      = rt_q;
    is_load_d = is_load_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          opcode_d  = req_opcode;
          rt_d      = req_rt;
          is_load_d = req_is_load;
          state_d   = req_err ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 4'(MEM_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs: each value is computed for the state being entered,
  // so the outputs are valid for the whole cycle of that state.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_opcode_d     = mem_opcode_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    wb_valid_d       = 1'b0;
    wb_rt_d          = wb_rt_q;
    wb_data_d        = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_address_d    = req_ea;
            mem_opcode_d     = req_opcode;
            mem_write_data_d = req_rs_val;
            mem_read_d       = req_is_load;
            mem_write_d      = req_is_store;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          mem_address_d = PARK_ADDR;
          resp_valid_d  = 1'b1;
          if (is_load_q) begin
            wb_valid_d = 1'b1;
            wb_rt_d    = rt_q;
            case (opcode_q)
              OP_LBZ:  wb_data_d = {56'd0, mem_read_data[7:0]};
              OP_LHZ:  wb_data_d = {48'd0, mem_read_data[15:0]};
              OP_LHA:  wb_data_d = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
              OP_LWZ:  wb_data_d = {32'd0, mem_read_data[31:0]};
              default: wb_data_d = mem_read_data;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_opcode     = mem_opcode_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rt          = wb_rt_q;
  assign wb_data        = wb_data_q;

endmodule
`default_nettype wire
